unified_mem_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read memory between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Accepts one transaction at a time over valid/ready handshakes, sequences it through the memory, and returns a one-cycle response pulse to the owner.
- D has priority, with an anti-starvation counter so IF always makes progress.
- Sits between the core pipeline and the unified memory, replacing the separate instruction and data memory instances.

---
 rtl/unified_mem_arbiter_if.sv | 48 ++++
 rtl/unified_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of request, response and memory-side signals for unified_mem_arbiter.
//   master : arbiter side. It takes the two requests and mem_rdata, and drives
//            the grants, the responses, the memory command and busy.
//   slave  : environment side (core pipeline plus the unified memory).
// Request side : if_req_valid/ready, if_addr, d_req_valid/ready, d_addr,
//                d_wmask, d_wdata
// Response side: if_resp_valid/data, d_resp_valid/data
// Memory side  : mem_addr, mem_w_mask, mem_wdata, mem_rdata
// Status       : busy
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [7:0]        d_wmask;
  logic [DATA_W-1:0] d_wdata;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_w_mask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    input  if_req_valid, if_addr, d_req_valid, d_addr, d_wmask, d_wdata, mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data,
           d_req_ready, d_resp_valid, d_resp_data,
           mem_addr, mem_w_mask, mem_wdata, busy
  );

  modport slave (
    output if_req_valid, if_addr, d_req_valid, d_addr, d_wmask, d_wdata, mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data,
           d_req_ready, d_resp_valid, d_resp_data,
           mem_addr, mem_w_mask, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported, synchronous-read memory
// between the instruction-fetch port (IF) and the load/store port (D).
// Only one transaction is in flight at a time. It runs IDLE -> ISSUE -> WAIT
// (MEM_LAT cycles) -> RESP. The owner gets a one-cycle response pulse in RESP.
// A new request can be accepted in that same RESP cycle.
// D has priority. After STARVE_MAX consecutive D grants taken while IF was
// waiting, the next contested grant goes to IF.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : unified_mem_arbiter_if.master (requests, responses, memory, busy)
module unified_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,   // 1..7
  parameter int STARVE_MAX = 4    // 1..15
)(
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.master bus
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        wait_q;
  logic [3:0]        starve_q;
  logic              own_d_q;     // 1: D owns the transaction in flight
  logic              is_wr_q;     // transaction in flight is a D write
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_w_mask_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept_win;
  logic              pick_d;
  logic              d_hs;
  logic              if_hs;
  logic              hs;
  logic              resp_if;
  logic              resp_d;

  // Grant and next state. The readies are gated by rst so that every output
  // is already low while reset is asserted, even when a valid is held high.
  always_comb begin
    accept_win = 1'b0;
    pick_d     = 1'b0;
    d_hs       = 1'b0;
    if_hs      = 1'b0;
    hs         = 1'b0;
    state_d    = state_q;

    accept_win = rst && (state_q == S_IDLE || state_q == S_RESP);
    // D wins a contested grant unless IF has already waited STARVE_MAX times.
    pick_d = bus.d_req_valid && !(bus.if_req_valid && starve_q == SMAX);
    d_hs   = accept_win && pick_d;
    if_hs  = accept_win && bus.if_req_valid && !pick_d;
    hs     = d_hs || if_hs;

    case (state_q)
      S_IDLE:  if (hs) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_q == 3'd0) state_d = S_RESP;
      S_RESP:  state_d = hs ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath. The memory command is loaded straight from the granted request
  // at the handshake edge, so it is already valid during the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q       <= '0;
      starve_q     <= '0;
      own_d_q      <= 1'b0;
      is_wr_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_mask_q <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      if (hs) begin
        own_d_q      <= d_hs;
        is_wr_q      <= d_hs && (bus.d_wmask != 8'h00);
        mem_addr_q   <= d_hs ? bus.d_addr : bus.if_addr;
        mem_w_mask_q <= d_hs ? bus.d_wmask : 8'h00;
        if (d_hs) mem_wdata_q <= bus.d_wdata;
        // The starvation count advances only on a D grant that IF also wanted.
        if (d_hs && bus.if_req_valid)
          starve_q <= (starve_q == SMAX) ? SMAX : starve_q + 4'd1;
        else
          starve_q <= '0;
      end else begin
        // The write enables only ever last for the one ISSUE cycle.
        mem_w_mask_q <= 8'h00;
      end

      if (state_q == S_ISSUE)
        wait_q <= LAT_M1;
      else if (state_q == S_WAIT && wait_q != 3'd0)
        wait_q <= wait_q - 3'd1;

      // Register read data on the last WAIT edge. A write returns zero.
      if (state_q == S_WAIT && wait_q == 3'd0)
        rdata_q <= is_wr_q ? '0 : bus.mem_rdata;
    end
  end

  assign resp_if = (state_q == S_RESP) && !own_d_q;
  assign resp_d  = (state_q == S_RESP) &&  own_d_q;

  assign bus.if_req_ready  = if_hs;
  assign bus.d_req_ready   = d_hs;
  assign bus.if_resp_valid = resp_if;
  assign bus.if_resp_data  = resp_if ? rdata_q : '0;
  assign bus.d_resp_valid  = resp_d;
  assign bus.d_resp_data   = resp_d ? rdata_q : '0;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_w_mask    = mem_w_mask_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter. The directed scenarios use a
// MEM_LAT=1 instance, except the latency-3 back-to-back case, which uses a
// second instance. A randomized run is checked against a transaction-level
// model built from the arbitration, latency and memory rules.
module tb_unified_mem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 64;
  localparam int SMAX = 4;
  localparam int LAT1 = 1;

  typedef struct {
    int          due;
    bit          own_d;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();
  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3();

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX))
    u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(SMAX))
    u_lat3 (.clk(clk), .rst(rst), .bus(bus3));

  wire [220:0] outs1 = {bus1.if_req_ready, bus1.if_resp_valid, bus1.if_resp_data,
                        bus1.d_req_ready, bus1.d_resp_valid, bus1.d_resp_data,
                        bus1.mem_addr, bus1.mem_w_mask, bus1.mem_wdata, bus1.busy};
  wire [220:0] outs3 = {bus3.if_req_ready, bus3.if_resp_valid, bus3.if_resp_data,
                        bus3.d_req_ready, bus3.d_resp_valid, bus3.d_resp_data,
                        bus3.mem_addr, bus3.mem_w_mask, bus3.mem_wdata, bus3.busy};

  // Memory model: 128 words indexed by addr[9:3]. A word that has never been
  // written reads a fixed pattern, and word 8 (0x0040) is preloaded.
  logic [63:0]  mem1 [128];
  logic [127:0] wr1;
  logic [63:0]  pipe1;
  logic [63:0]  pipe3 [3];

  function automatic logic [63:0] dflt(input logic [6:0] i);
    if (i == 7'd8) return 64'hDEAD_BEEF_0000_1111;
    return {8{1'b0, i}} ^ 64'h0F1E_2D3C_4B5A_6978;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rd1(input logic [6:0] i);
    return wr1[i] ? mem1[i] : dflt(i);
  endfunction

  always @(posedge clk) begin
    pipe1 <= rd1(bus1.mem_addr[9:3]);
    if (cyc == 0) wr1 <= '0;
    else if (bus1.mem_w_mask != 8'h00) begin
      mem1[bus1.mem_addr[9:3]] <= merge(rd1(bus1.mem_addr[9:3]), bus1.mem_wdata, bus1.mem_w_mask);
      wr1[bus1.mem_addr[9:3]]  <= 1'b1;
    end
    pipe3[0] <= dflt(bus3.mem_addr[9:3]);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign bus1.mem_rdata = pipe1;
  assign bus3.mem_rdata = pipe3[2];

  task automatic test_reset();
    rst = 1'b0;
    bus1.if_req_valid = 1'b1; bus1.d_req_valid = 1'b1;
    bus3.if_req_valid = 1'b1; bus3.d_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (outs1 !== '0) begin n_fail++; $display("FAIL reset_outs_lat1: got %h want 0", outs1); end
    n_chk++; if (outs3 !== '0) begin n_fail++; $display("FAIL reset_outs_lat3: got %h want 0", outs3); end
    @(posedge clk); #1;
    bus1.if_req_valid = 1'b0; bus1.d_req_valid = 1'b0;
    bus3.if_req_valid = 1'b0; bus3.d_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b want 0", bus1.busy); end
  endtask

  task automatic test_if_read();
    @(posedge clk); #1;
    bus1.if_req_valid = 1'b1; bus1.if_addr = 16'h0040;
    @(negedge clk);
    n_chk++; if (bus1.if_req_ready !== 1'b1) begin n_fail++; $display("FAIL ifrd_ready: got %b want 1", bus1.if_req_ready); end
    n_chk++; if (bus1.d_req_ready !== 1'b0) begin n_fail++; $display("FAIL ifrd_dready: got %b want 0", bus1.d_req_ready); end
    @(posedge clk); #1;
    bus1.if_req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (bus1.mem_addr !== 16'h0040) begin n_fail++; $display("FAIL ifrd_issue_addr: got %h want 0040", bus1.mem_addr); end
    n_chk++; if (bus1.mem_w_mask !== 8'h00) begin n_fail++; $display("FAIL ifrd_issue_mask: got %h want 00", bus1.mem_w_mask); end
    @(negedge clk);
    n_chk++; if (bus1.if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ifrd_early_resp: got %b want 0", bus1.if_resp_valid); end
    @(negedge clk);
    n_chk++; if (bus1.if_resp_valid !== 1'b1) begin n_fail++; $display("FAIL ifrd_resp_valid: got %b want 1", bus1.if_resp_valid); end
    n_chk++; if (bus1.if_resp_data !== 64'hDEAD_BEEF_0000_1111) begin n_fail++; $display("FAIL ifrd_resp_data: got %h want deadbeef00001111", bus1.if_resp_data); end
    n_chk++; if (bus1.d_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ifrd_d_resp: got %b want 0", bus1.d_resp_valid); end
    @(negedge clk);
    n_chk++; if ({bus1.if_resp_valid, bus1.if_resp_data, bus1.busy} !== '0) begin
      n_fail++; $display("FAIL ifrd_after: got v=%b d=%h busy=%b want 0", bus1.if_resp_valid, bus1.if_resp_data, bus1.busy); end
  endtask

  task automatic test_d_write();
    @(posedge clk); #1;
    bus1.d_req_valid = 1'b1; bus1.d_addr = 16'h0100; bus1.d_wmask = 8'h0F;
    bus1.d_wdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    n_chk++; if (bus1.d_req_ready !== 1'b1) begin n_fail++; $display("FAIL dwr_ready: got %b want 1", bus1.d_req_ready); end
    @(posedge clk); #1;
    bus1.d_req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (bus1.mem_w_mask !== 8'h0F) begin n_fail++; $display("FAIL dwr_issue_mask: got %h want 0f", bus1.mem_w_mask); end
    n_chk++; if (bus1.mem_addr !== 16'h0100) begin n_fail++; $display("FAIL dwr_issue_addr: got %h want 0100", bus1.mem_addr); end
    n_chk++; if (bus1.mem_wdata !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL dwr_issue_wdata: got %h want 1122334455667788", bus1.mem_wdata); end
    @(negedge clk);
    n_chk++; if (bus1.mem_w_mask !== 8'h00) begin n_fail++; $display("FAIL dwr_wait_mask: got %h want 00", bus1.mem_w_mask); end
    @(negedge clk);
    n_chk++; if (bus1.d_resp_valid !== 1'b1) begin n_fail++; $display("FAIL dwr_resp_valid: got %b want 1", bus1.d_resp_valid); end
    n_chk++; if (bus1.d_resp_data !== 64'h0) begin n_fail++; $display("FAIL dwr_resp_data: got %h want 0", bus1.d_resp_data); end
    n_chk++; if (bus1.if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL dwr_if_resp: got %b want 0", bus1.if_resp_valid); end
    @(negedge clk);
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL dwr_busy_after: got %b want 0", bus1.busy); end
  endtask

  task automatic test_starvation();
    string seq;
    int    hs_cyc [10];
    int    n;
    seq = ""; n = 0;
    @(posedge clk); #1;
    bus1.d_req_valid = 1'b1; bus1.d_addr = 16'h0108; bus1.d_wmask = 8'h00;
    bus1.if_req_valid = 1'b1; bus1.if_addr = 16'h0048;
    for (int k = 0; k < 80 && n < 10; k++) begin
      @(negedge clk);
      if (bus1.d_req_ready || bus1.if_req_ready) begin
        seq = {seq, bus1.d_req_ready ? "D" : "I"};
        hs_cyc[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    bus1.d_req_valid = 1'b0; bus1.if_req_valid = 1'b0;
    n_chk++; if (n !== 10) begin n_fail++; $display("FAIL starve_count: got %0d grants want 10", n); end
    n_chk++; if (seq != "DDDDIDDDDI") begin n_fail++; $display("FAIL starve_seq: got %s want DDDDIDDDDI", seq); end
    for (int i = 1; i < n; i++) begin
      n_chk++; if (hs_cyc[i] - hs_cyc[i-1] !== 3) begin
        n_fail++; $display("FAIL starve_spacing: got %0d cycles want 3", hs_cyc[i] - hs_cyc[i-1]); end
    end
    for (int k = 0; k < 20 && bus1.busy; k++) @(negedge clk);
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL starve_drain: got busy=%b want 0", bus1.busy); end
  endtask

  task automatic test_d_stream();
    string seq;
    int    n;
    seq = ""; n = 0;
    @(posedge clk); #1;
    bus1.d_req_valid = 1'b1; bus1.d_addr = 16'h0110; bus1.d_wmask = 8'h00;
    bus1.if_req_valid = 1'b0; bus1.if_addr = 16'h0058;
    for (int k = 0; k < 100 && n < 11; k++) begin
      @(negedge clk);
      if (bus1.d_req_ready || bus1.if_req_ready) begin
        seq = {seq, bus1.d_req_ready ? "D" : "I"};
        n++;
      end
      @(posedge clk); #1;
      if (n >= 6) bus1.if_req_valid = 1'b1;
      if (n >= 11) begin bus1.d_req_valid = 1'b0; bus1.if_req_valid = 1'b0; end
    end
    bus1.d_req_valid = 1'b0; bus1.if_req_valid = 1'b0;
    n_chk++; if (seq != "DDDDDDDDDDI") begin n_fail++; $display("FAIL dstream_seq: got %s want DDDDDDDDDDI", seq); end
    for (int k = 0; k < 20 && bus1.busy; k++) @(negedge clk);
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL dstream_drain: got busy=%b want 0", bus1.busy); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus3.d_req_valid = 1'b1; bus3.d_addr = 16'h0080; bus3.d_wmask = 8'h00;
    @(negedge clk);
    n_chk++; if (bus3.d_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b want 1", bus3.d_req_ready); end
    @(posedge clk); #1;
    bus3.d_addr = 16'h00C8;
    @(negedge clk);
    n_chk++; if (bus3.mem_addr !== 16'h0080) begin n_fail++; $display("FAIL b2b_issue1_addr: got %h want 0080", bus3.mem_addr); end
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      n_chk++; if ({bus3.d_resp_valid, bus3.d_req_ready} !== 2'b00) begin
        n_fail++; $display("FAIL b2b_wait: got resp=%b ready=%b want 0 at T+%0d", bus3.d_resp_valid, bus3.d_req_ready, i); end
    end
    @(negedge clk);
    n_chk++; if (bus3.d_resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_resp1_valid: got %b want 1", bus3.d_resp_valid); end
    n_chk++; if (bus3.d_resp_data !== dflt(7'd16)) begin n_fail++; $display("FAIL b2b_resp1_data: got %h want %h", bus3.d_resp_data, dflt(7'd16)); end
    n_chk++; if (bus3.d_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready: got %b want 1", bus3.d_req_ready); end
    @(posedge clk); #1;
    bus3.d_req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus3.mem_addr, bus3.busy, bus3.d_resp_valid} !== {16'h00C8, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL b2b_issue2: got addr=%h busy=%b resp=%b want 00c8 1 0", bus3.mem_addr, bus3.busy, bus3.d_resp_valid); end
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_chk++; if (bus3.d_resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_resp2_valid: got %b want 1", bus3.d_resp_valid); end
    n_chk++; if (bus3.d_resp_data !== dflt(7'd25)) begin n_fail++; $display("FAIL b2b_resp2_data: got %h want %h", bus3.d_resp_data, dflt(7'd25)); end
    @(negedge clk);
    n_chk++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", bus3.busy); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    bus1.if_req_valid = 1'b1; bus1.if_addr = 16'h0048;
    @(negedge clk);
    n_chk++; if (bus1.if_req_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", bus1.if_req_ready); end
    @(posedge clk); #1;
    bus1.if_req_valid = 1'b0;
    @(posedge clk); #2;           // now in WAIT
    rst = 1'b0;
    #1;
    n_chk++; if (outs1 !== '0) begin n_fail++; $display("FAIL arst_outs: got %h want 0", outs1); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++; if (bus1.if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_resp: got %b want 0", bus1.if_resp_valid); end
    end
    @(posedge clk); #1;
    bus1.if_req_valid = 1'b1; bus1.if_addr = 16'h0050;
    @(negedge clk);
    n_chk++; if (bus1.if_req_ready !== 1'b1) begin n_fail++; $display("FAIL arst_next_ready: got %b want 1", bus1.if_req_ready); end
    @(posedge clk); #1;
    bus1.if_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    n_chk++; if ({bus1.if_resp_valid, bus1.if_resp_data} !== {1'b1, dflt(7'd10)}) begin
      n_fail++; $display("FAIL arst_next_resp: got %b %h want 1 %h", bus1.if_resp_valid, bus1.if_resp_data, dflt(7'd10)); end
    @(negedge clk);
    n_chk++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL arst_next_idle: got %b want 0", bus1.busy); end
  endtask

  task automatic test_random();
    exp_t        q [$];
    logic [63:0] refm [128];
    bit          refw [128];
    int          next_ok, starve, last_hs, iss_cyc;
    logic [7:0]  iss_mask, e_mask;
    logic [15:0] iss_addr;
    logic [63:0] dat, e_data;
    logic [6:0]  idx;
    bit          ip, dp, ok, ed, ei, e_iv, e_dv, e_busy;
    for (int i = 0; i < 128; i++) refw[i] = 1'b0;
    next_ok = 0; starve = 0; last_hs = -100; iss_cyc = -100;
    iss_mask = 8'h00; iss_addr = '0; ip = 1'b0; dp = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 620; k++) begin
      if (k < 600 && !ip && $urandom_range(0, 2) == 0) begin
        ip = 1'b1; bus1.if_req_valid = 1'b1;
        bus1.if_addr = 16'h0200 + 16'($urandom_range(0, 15)) * 16'd8;
      end
      if (k < 600 && !dp && $urandom_range(0, 2) == 0) begin
        dp = 1'b1; bus1.d_req_valid = 1'b1;
        bus1.d_addr  = 16'h0200 + 16'($urandom_range(0, 15)) * 16'd8;
        bus1.d_wmask = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        bus1.d_wdata = {$urandom, $urandom};
      end
      @(negedge clk);
      ok = (cyc >= next_ok);
      ed = ok && dp && !(ip && starve == SMAX);
      ei = ok && ip && !ed;
      n_chk++; if ({bus1.d_req_ready, bus1.if_req_ready} !== {ed, ei}) begin
        n_fail++; $display("FAIL rnd_grant: got d=%b if=%b want d=%b if=%b cyc %0d", bus1.d_req_ready, bus1.if_req_ready, ed, ei, cyc); end
      e_mask = (cyc == iss_cyc) ? iss_mask : 8'h00;
      n_chk++; if (bus1.mem_w_mask !== e_mask) begin n_fail++; $display("FAIL rnd_wmask: got %h want %h cyc %0d", bus1.mem_w_mask, e_mask, cyc); end
      if (cyc == iss_cyc) begin
        n_chk++; if (bus1.mem_addr !== iss_addr) begin n_fail++; $display("FAIL rnd_addr: got %h want %h", bus1.mem_addr, iss_addr); end
      end
      e_busy = (cyc > last_hs) && (cyc <= last_hs + 2 + LAT1);
      n_chk++; if (bus1.busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy: got %b want %b cyc %0d", bus1.busy, e_busy, cyc); end
      e_iv = 1'b0; e_dv = 1'b0; e_data = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_iv = !q[0].own_d; e_dv = q[0].own_d; e_data = q[0].data;
        void'(q.pop_front());
      end
      n_chk++; if ({bus1.if_resp_valid, bus1.if_resp_data} !== {e_iv, e_iv ? e_data : 64'h0}) begin
        n_fail++; $display("FAIL rnd_if_resp: got %b %h want %b %h", bus1.if_resp_valid, bus1.if_resp_data, e_iv, e_iv ? e_data : 64'h0); end
      n_chk++; if ({bus1.d_resp_valid, bus1.d_resp_data} !== {e_dv, e_dv ? e_data : 64'h0}) begin
        n_fail++; $display("FAIL rnd_d_resp: got %b %h want %b %h", bus1.d_resp_valid, bus1.d_resp_data, e_dv, e_dv ? e_data : 64'h0); end
      if (ed || ei) begin
        last_hs = cyc; next_ok = cyc + LAT1 + 2; iss_cyc = cyc + 1;
        if (ed) begin
          idx = bus1.d_addr[9:3];
          iss_addr = bus1.d_addr; iss_mask = bus1.d_wmask;
          if (bus1.d_wmask != 8'h00) begin
            refm[idx] = merge(refw[idx] ? refm[idx] : dflt(idx), bus1.d_wdata, bus1.d_wmask);
            refw[idx] = 1'b1;
            dat = '0;
          end else begin
            dat = refw[idx] ? refm[idx] : dflt(idx);
          end
          starve = ip ? ((starve == SMAX) ? SMAX : starve + 1) : 0;
          q.push_back('{due: cyc + 2 + LAT1, own_d: 1'b1, data: dat});
          dp = 1'b0;
        end else begin
          idx = bus1.if_addr[9:3];
          iss_addr = bus1.if_addr; iss_mask = 8'h00;
          dat = refw[idx] ? refm[idx] : dflt(idx);
          starve = 0;
          q.push_back('{due: cyc + 2 + LAT1, own_d: 1'b0, data: dat});
          ip = 1'b0;
        end
      end
      @(posedge clk); #1;
      if (!ip) bus1.if_req_valid = 1'b0;
      if (!dp) bus1.d_req_valid = 1'b0;
    end
    n_chk++; if (q.size() !== 0) begin n_fail++; $display("FAIL rnd_outstanding: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.if_req_valid = 1'b0; bus1.if_addr = '0; bus1.d_req_valid = 1'b0;
    bus1.d_addr = '0; bus1.d_wmask = '0; bus1.d_wdata = '0;
    bus3.if_req_valid = 1'b0; bus3.if_addr = '0; bus3.d_req_valid = 1'b0;
    bus3.d_addr = '0; bus3.d_wmask = '0; bus3.d_wdata = '0;
    test_reset();
    test_if_read();
    test_d_write();
    test_starvation();
    test_d_stream();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
